// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control unit.
// Holds the FSM state enumeration, the opcode constants and the mux select
// encodings for ResultSrc, ALUSrcA, ALUSrcB and ALUOp.
// Optional feature macro: JAL_SUPPORT_EN (adds the JAL state).
package multi_cycle_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBeq,
`ifdef JAL_SUPPORT_EN
    StJal,
`endif
    StIllegal
  } state_e;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResData      = 2'b01,
    ResAluResult = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARd1   = 2'b10
  } src_a_e;

  typedef enum logic [1:0] {
    SrcBRd2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } src_b_e;

  typedef enum logic [1:0] {
    AluOpAdd  = 2'b00,
    AluOpSub  = 2'b01,
    AluOpFunc = 2'b10
  } alu_op_e;

endpackage

// File: rtl/multi_cycle_ctrl_alu_dec.sv
// mc_alu_dec: combinational ALU control decoder.
// Ports:
//   alu_op_i      - operation class from the FSM (add / sub / by funct)
//   funct3_i      - instruction funct3
//   funct7_i      - instruction bit 30
//   op5_i         - OPCODE[5], distinguishes R-type from I-type
//   alu_control_o - ALU operation, zero-extended to ALU_CTRL_W
module mc_alu_dec
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3
) (
  input  alu_op_e               alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7_i,
  input  logic                  op5_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o
);

  logic [2:0] ctrl;

  always_comb begin
    ctrl = 3'd0;
    case (alu_op_i)
      AluOpAdd: ctrl = 3'd0;
      AluOpSub: ctrl = 3'd2;
      AluOpFunc: begin
        case (funct3_i)
          // Only R-type can subtract; addi ignores bit 30.
          3'b000:                                    ctrl = (op5_i && funct7_i) ? 3'd2 : 3'd0;
          3'b001, 3'b100, 3'b101, 3'b110, 3'b111:    ctrl = funct3_i;
          default:                                   ctrl = 3'd0;
        endcase
      end
      default: ctrl = 3'd0;
    endcase
  end

  assign alu_control_o = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: Moore FSM controller for a multi-cycle RISC-V datapath,
// with branch condition evaluation and a retired-instruction counter.
// Optional feature macro: JAL_SUPPORT_EN (JAL state and ImmSrc=11).
// Ports:
//   CLK, RST                 - clock, async active-low reset
//   OPCODE, funct3, funct7   - instruction fields from the IR
//   Zero, sign_flag          - ALU flags for branches
//   MemReady                 - memory handshake
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl, RegWrite - datapath controls
//   ILLEGAL                  - sticky unsupported-opcode flag
//   INSTR_CNT                - retired-instruction count (wraps)
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            OPCODE,
  input  logic [2:0]            funct3,
  input  logic                  funct7,
  input  logic                  Zero,
  input  logic                  sign_flag,
  input  logic                  MemReady,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  RegWrite,
  output logic                  ILLEGAL,
  output logic [CNT_W-1:0]      INSTR_CNT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        pc_write, mem_write, ir_write, reg_write, adr_src;
  result_src_e result_src;
  src_a_e      alu_src_a;
  src_b_e      alu_src_b;
  alu_op_e     alu_op;
  logic        taken;
  logic        retire;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = sign_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRd2;
    alu_op     = AluOpAdd;
    case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = MemReady;
        pc_write   = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (OPCODE)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
`ifdef JAL_SUPPORT_EN
          OpJal:           state_d = StJal;
`endif
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
        state_d   = OPCODE[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = StFetch;
      end
      StExecR: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBRd2;
        alu_op    = AluOpFunc;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunc;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        alu_src_a = SrcARd1;
        alu_src_b = SrcBRd2;
        alu_op    = AluOpSub;
        pc_write  = taken;
        state_d   = StFetch;
      end
`ifdef JAL_SUPPORT_EN
      StJal: begin
        // PC <= branch target from ALUOut; ALU forms OldPC+4 for the link.
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
`endif
      StIllegal: state_d = StIllegal;
      default:   state_d = StFetch;
    endcase
  end

  assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
                  ((state_q == StMemWrite) && MemReady);

  always_comb begin
    cnt_d = cnt_q;
    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (OPCODE)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
`ifdef JAL_SUPPORT_EN
      OpJal:    ImmSrc = 2'b11;
`endif
      default:  ImmSrc = 2'b00;
    endcase
  end

  mc_alu_dec #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .funct7_i      (funct7),
    .op5_i         (OPCODE[5]),
    .alu_control_o (ALUControl)
  );

  // FETCH would otherwise raise enables while held in reset.
  assign PCWrite   = pc_write  & RST;
  assign MemWrite  = mem_write & RST;
  assign IRWrite   = ir_write  & RST;
  assign RegWrite  = reg_write & RST;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ILLEGAL   = (state_q == StIllegal);
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl (CNT_W=4 to reach wrap quickly).
module tb_multi_cycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;
`ifdef JAL_SUPPORT_EN
  localparam logic [1:0] JAL_IMM = 2'b11;
`else
  localparam logic [1:0] JAL_IMM = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7, zero, sign, mem_ready;
  logic       pcw, adr, mw, irw, rw, ill;
  logic [1:0] res, srca, srcb, imm;
  logic [2:0] aluc;
  logic [3:0] cnt;
  logic [16:0] outv;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(
    .ALU_CTRL_W(3),
    .CNT_W     (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .OPCODE    (opcode),
    .funct3    (f3),
    .funct7    (f7),
    .Zero      (zero),
    .sign_flag (sign),
    .MemReady  (mem_ready),
    .PCWrite   (pcw),
    .AdrSrc    (adr),
    .MemWrite  (mw),
    .IRWrite   (irw),
    .ResultSrc (res),
    .ALUSrcA   (srca),
    .ALUSrcB   (srcb),
    .ImmSrc    (imm),
    .ALUControl(aluc),
    .RegWrite  (rw),
    .ILLEGAL   (ill),
    .INSTR_CNT (cnt)
  );

  assign outv = {pcw, adr, mw, irw, res, srca, srcb, imm, aluc, rw, ill};

  function automatic logic [16:0] ev(input logic p, input logic a, input logic m, input logic i,
                                     input logic [1:0] r, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] im,
                                     input logic [2:0] ac, input logic w, input logic il);
    return {p, a, m, i, r, sa, sb, im, ac, w, il};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [16:0] exp);
    #1;
    n_checks++;
    assert (outv === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%05h expected=%05h", tag, outv, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (cnt === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, cnt, exp);
    end
  endtask

  // FETCH (MemReady=1) then DECODE; leaves the FSM in the execute state.
  task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [1:0] exp_imm);
    opcode    = op;
    mem_ready = 1'b1;
    chk_out({tag, "_fetch"}, ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, exp_imm, 3'd0, 0, 0));
    tick();
    chk_out({tag, "_decode"}, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, exp_imm, 3'd0, 0, 0));
    tick();
  endtask

  task automatic branch(input string tag, input logic [2:0] fn, input logic z, input logic s,
                        input logic exp_pcw);
    f3   = fn;
    zero = z;
    sign = s;
    fetch_decode(tag, OP_B, 2'b10);
    chk_out({tag, "_beq"}, ev(exp_pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'd2, 0, 0));
    tick();
  endtask

  task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] fn,
                           input logic fn7, input logic [1:0] exp_b, input logic [2:0] exp_ac);
    f3 = fn;
    f7 = fn7;
    fetch_decode(tag, op, 2'b00);
    chk_out({tag, "_exec"}, ev(0, 0, 0, 0, 2'b00, 2'b10, exp_b, 2'b00, exp_ac, 0, 0));
    tick();
    chk_out({tag, "_aluwb"}, ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 1, 0));
    tick();
  endtask

  initial begin
    rst = 1'b0; opcode = OP_LW; f3 = 3'd0; f7 = 1'b0; zero = 1'b0; sign = 1'b0;
    mem_ready = 1'b1;
    #2;
    chk_out("reset_outputs", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 0, 0));
    chk_cnt("reset_cnt", 4'd0);
    tick();
    tick();
    rst = 1'b1;

    // lw with a one-cycle memory stall in MEMREAD
    fetch_decode("lw", OP_LW, 2'b00);
    chk_out("lw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'd0, 0, 0));
    tick();
    mem_ready = 1'b0;
    chk_out("lw_memread_stall", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0));
    tick();
    mem_ready = 1'b1;
    chk_out("lw_memread", ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 0));
    tick();
    chk_out("lw_memwb", ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'd0, 1, 0));
    chk_cnt("lw_cnt_before", 4'd0);
    tick();
    chk_cnt("lw_cnt_after", 4'd1);

    // sw: fetch stall, then MEMWRITE stalled 3 cycles
    opcode    = OP_SW;
    mem_ready = 1'b0;
    chk_out("sw_fetch_stall", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'd0, 0, 0));
    tick();
    fetch_decode("sw", OP_SW, 2'b01);
    chk_out("sw_memadr", ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'd0, 0, 0));
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("sw_memwrite_stall", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0));
      chk_cnt("sw_cnt_stall", 4'd1);
      tick();
    end
    mem_ready = 1'b1;
    chk_out("sw_memwrite_last", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0));
    tick();
    chk_cnt("sw_cnt_after", 4'd2);

    // branches
    branch("beq_z1", 3'b000, 1'b1, 1'b0, 1'b1);
    branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
    branch("f3_010_s1", 3'b010, 1'b0, 1'b1, 1'b0);
    branch("blt_s1", 3'b100, 1'b0, 1'b1, 1'b1);
    chk_cnt("branch_cnt", 4'd6);

    // ALU decode
    alu_instr("sub", OP_R, 3'b000, 1'b1, 2'b00, 3'd2);
    alu_instr("addi_f7", OP_I, 3'b000, 1'b1, 2'b01, 3'd0);
    alu_instr("or", OP_R, 3'b110, 1'b0, 2'b00, 3'd6);
    alu_instr("slti", OP_I, 3'b010, 1'b0, 2'b01, 3'd0);
    chk_cnt("alu_cnt", 4'd10);

    // wrap the 4-bit counter
    for (int i = 0; i < 5; i++) alu_instr("addi", OP_I, 3'b000, 1'b0, 2'b01, 3'd0);
    chk_cnt("cnt_15", 4'd15);
    alu_instr("addi_wrap", OP_I, 3'b000, 1'b0, 2'b01, 3'd0);
    chk_cnt("cnt_wrap", 4'd0);

    // unsupported opcode: sticky ILLEGAL, cleared by reset
    fetch_decode("bad", OP_BAD, 2'b00);
    for (int i = 0; i < 10; i++) begin
      chk_out("illegal_hold", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1));
      tick();
    end
    rst = 1'b0;
    chk_out("illegal_reset", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'd0, 0, 0));
    chk_cnt("illegal_reset_cnt", 4'd0);
    tick();
    rst = 1'b1;

    // jal opcode
    fetch_decode("jal", OP_JAL, JAL_IMM);
`ifdef JAL_SUPPORT_EN
    chk_out("jal_state", ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'd0, 0, 0));
    tick();
    chk_out("jal_aluwb", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'd0, 1, 0));
    tick();
    chk_cnt("jal_cnt", 4'd1);
`else
    chk_out("jal_illegal", ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 0, 1));
    tick();
    chk_cnt("jal_cnt", 4'd0);
`endif
    rst = 1'b0;
    tick();
    rst = 1'b1;

    // reset mid-instruction aborts the store
    alu_instr("addi_pre", OP_I, 3'b000, 1'b0, 2'b01, 3'd0);
    chk_cnt("pre_abort_cnt", 4'd1);
    fetch_decode("sw2", OP_SW, 2'b01);
    tick();
    mem_ready = 1'b0;
    chk_out("sw2_memwrite", ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'd0, 0, 0));
    rst = 1'b0;
    chk_out("abort_outputs", ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'd0, 0, 0));
    chk_cnt("abort_cnt", 4'd0);
    tick();
    rst = 1'b1;
    tick();
    mem_ready = 1'b1;
    chk_out("post_abort_fetch", ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b01, 3'd0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL provide parameter ALU_CTRL_W, default 3, width of ALUControl.
REQ-002 SHALL provide parameter CNT_W, default 16, width of retired-instruction counter.
REQ-003 SHALL have exactly one clock and one reset; RST is asynchronous and active-low.
REQ-004 SHALL have these ports:
- CLK  in  1  rising-edge clock
- RST  in  1  async active-low reset
- OPCODE  in  7  instruction opcode, taken from the instruction register
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- sign_flag  in  1  ALU sign flag
- MemReady  in  1  memory access complete
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register and OldPC enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  ALU_CTRL_W  ALU operation
- RegWrite  out  1  register file write
- ILLEGAL  out  1  sticky unsupported-opcode flag
- INSTR_CNT  out  CNT_W  retired-instruction count

Function
REQ-005 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL and ILLEGAL.
REQ-006 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, and assert IRWrite and PCWrite only when MemReady=1; it SHALL hold in FETCH while MemReady=0, else go to DECODE.
REQ-007 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, add (branch target), then go to the next state by OPCODE: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> ILLEGAL.
REQ-008 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, add, then go to MEMREAD if OPCODE[5]=0, else MEMWRITE.
REQ-009 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and hold until MemReady=1, then go to MEMWB.
REQ-010 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-011 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00 and MemWrite=1, and hold until MemReady=1, then go to FETCH.
REQ-012 EXECUTER and EXECUTEI SHALL drive ALUSrcA=10 and ALUOp=10; ALUSrcB SHALL be 00 in EXECUTER and 01 in EXECUTEI; both SHALL go to ALUWB.
REQ-013 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-014 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, subtract, ResultSrc=00, and PCWrite=taken, then go to FETCH.
REQ-015 The branch-taken condition SHALL be: funct3 000 -> Zero; 001 -> !Zero; 100 -> sign_flag; any other funct3 -> not taken.
REQ-016 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00 and PCWrite=1, then go to ALUWB.
REQ-017 ILLEGAL SHALL drive all enables to 0, assert ILLEGAL=1, and remain in ILLEGAL until reset.
REQ-018 ImmSrc SHALL be derived combinationally from OPCODE: S-type 01, B-type 10, JAL 11, all others 00.
REQ-019 ALU decode SHALL be:
- ALUOp 00 -> 0 (add); ALUOp 01 -> 2 (sub).
- ALUOp 10 -> by funct3: 000 gives 2 only if OPCODE[5]=1 and funct7=1, else 0; 001, 100, 101, 110 and 111 pass funct3 through; all other funct3 -> 0.
- The result SHALL be zero-extended to ALU_CTRL_W.
REQ-020 INSTR_CNT SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ, and SHALL wrap modulo 2^CNT_W.
REQ-021 In every state, any enable not named for that state SHALL be 0.

Reset
REQ-022 On RST=0, the FSM SHALL enter FETCH asynchronously, clear INSTR_CNT and ILLEGAL, and hold all write enables at 0 while RST=0.
REQ-023 Reset asserted mid-instruction SHALL abort the instruction with no further write enables; the first cycle after release SHALL be FETCH.

Configuration
REQ-024 With macro JAL_SUPPORT_EN defined, opcode 1101111 SHALL decode to JAL; without it, the JAL state and ImmSrc=11 SHALL not exist and opcode 1101111 SHALL go to ILLEGAL.

Structure
REQ-025 A shared package SHALL hold the state enumeration, the opcode constants, and the ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-026 ALU decode SHALL be one combinational sub-module named mc_alu_dec; the FSM, counter and branch logic SHALL reside in multi_cycle_ctrl.

Verification
REQ-027 lw (OPCODE 0000011) with MemReady=1 throughout -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles); RegWrite=1 only in MEMWB; INSTR_CNT goes 0 -> 1.
REQ-028 sw with MemReady held 0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; INSTR_CNT increments once.
REQ-029 beq with Zero=1 -> PCWrite=1 in BEQ; bne with Zero=1 -> PCWrite=0; funct3=010 with sign_flag=1 -> PCWrite=0.
REQ-030 R-type sub (funct3=000, funct7=1) -> ALUControl=2 in EXECUTER; addi with funct7=1 -> ALUControl=0.
REQ-031 OPCODE 1111111 -> ILLEGAL=1 and stays 1 for 10 cycles; RST pulsed low -> FETCH, ILLEGAL=0, INSTR_CNT=0.
REQ-032 With CNT_W=4, retire 16 instructions -> INSTR_CNT wraps to 0; with JAL_SUPPORT_EN undefined, OPCODE 1101111 -> ILLEGAL.
